tdm_demux_1to4: RTL and testbench
=================================

Name: tdm_demux_1to4

Overview:
- Clocked 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the 4-to-1 mux.
- Takes a single serial bit stream framed by a sync pulse and splits it into four slots of WIDTH bits each, in channel order ch0..ch3.
- Each completed slot is latched into its own parallel output register, with a one-cycle valid strobe.
- Sits after the line-side 4:1 mux/serializer in the switch-level datapath experiments.

Parameters:
- WIDTH, 8, data bits per slot (legal range 2..32); a frame is 4*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  bit-enable; din and sync are sampled only when en=1
- sync  input  1  frame start; qualified by en; marks din as bit 0 of slot 0
- din  input  1  serial data, MSB of each slot first
- ch0  output  WIDTH  slot 0 data register
- ch1  output  WIDTH  slot 1 data register
- ch2  output  WIDTH  slot 2 data register
- ch3  output  WIDTH  slot 3 data register
- ch_valid  output  4  one-cycle strobe, bit n = chn updated this cycle
- frame_done  output  1  one-cycle strobe when slot 3 completes
- frame_err  output  1  one-cycle strobe when sync arrives mid-frame

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit_cnt=0, slot_cnt=0, shift register=0, ch0..ch3=0, ch_valid=0, frame_done=0, frame_err=0. Reset asserted mid-frame discards the partial frame.
- States:
  - IDLE: waits for en&sync. On that edge, din is shifted in as bit 0 of slot 0, bit_cnt=1, slot_cnt=0, and the state goes to RUN. en=1 with sync=0 in IDLE is ignored.
  - RUN: each en=1 edge shifts din into the LSB of the shift register and increments bit_cnt. en=0 holds all counters and the shift register.
- Slot completion: on the en=1 edge where bit_cnt==WIDTH-1, ch[slot_cnt] <= {shift[WIDTH-2:0],din}. On that same edge, ch_valid[slot_cnt] is registered to 1, so it is high for exactly the following cycle. bit_cnt then clears to 0 and slot_cnt increments.
- Latency: chN and ch_valid[N] are visible one clock after the edge that samples the last bit of slot N.
- Frame end: completing slot 3 also registers frame_done=1 for one cycle, clears slot_cnt to 0, and returns the state to IDLE. A sync coincident with that last bit is not a new frame and is treated as a mid-frame sync (below).
- Mid-frame sync: en&sync in RUN (any bit other than bit 0 of a new frame), including on the last bit of slot 3:
  - frame_err pulses for one cycle.
  - The partial slot is discarded; no ch_valid or frame_done is raised for it.
  - The framer restarts with din as bit 0 of slot 0, and the state stays RUN.
  - Slots already completed earlier in the aborted frame keep their latched values.
- Output hold: ch0..ch3 hold their values between updates. ch_valid, frame_done and frame_err are 0 whenever not pulsing.
- At most one bit of ch_valid is set in any cycle.
- Counters: bit_cnt is $clog2(WIDTH+1) bits and slot_cnt is 2 bits. Neither wraps except by the rules above.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN
- Defined:
  - Each slot is WIDTH+1 bits: WIDTH data bits followed by one even-parity bit.
  - The data register and ch_valid update on the parity-bit edge, and only if XOR(data,parity)==0.
  - On a mismatch, chN is left unchanged, ch_valid stays 0, and the extra output port par_err[3:0] pulses bit N for one cycle.
  - Slot sequencing still advances, and frame_done still pulses after slot 3.
- Undefined: no parity bit, slot length is WIDTH, and the par_err port is absent.

Test Plan (WIDTH=8, en=1 unless stated):
- Reset then clean frame: sync with 32 bits A5,3C,FF,01 MSB-first -> ch_valid 0001,0010,0100,1000 one cycle after bits 7,15,23,31; ch0..ch3=A5,3C,FF,01; frame_done pulses after bit 31.
- en gaps: same frame with en=0 inserted every 3rd cycle -> identical outputs; strobes delayed only by the stall cycles.
- Mid-frame sync: sync again at bit 12 of a frame, then a full frame 11,22,33,44 -> frame_err pulses once; ch0 keeps the earlier value until overwritten; final ch0..ch3=11,22,33,44.
- Bits without sync in IDLE: 40 bits of 1 with sync=0 -> ch registers stay 00 and no strobes fire.
- Async reset mid-frame: rst_n low at bit 20 -> all outputs 0 immediately without waiting for a clock edge; after release, a new frame decodes normally.
- TDM_DEMUX_PARITY_EN: slot0=A5 with parity 0 (good), slot1=3C with parity 1 (bad) -> ch0=A5 with valid pulse; ch1 unchanged; par_err=0010 pulse; frame_done still pulses.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
// Receive-side 1-to-4 time-division demultiplexer. A serial bit stream framed
// by a sync pulse is split into four slots of WIDTH bits (MSB first), in
// channel order ch0..ch3. Each completed slot is latched into its own output
// register together with a one-cycle valid strobe.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN
//   When defined, each slot carries WIDTH data bits followed by one even-parity
//   bit. A slot is only latched when the parity checks. Otherwise the slot is
//   dropped and par_err pulses for that channel.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   bit enable; din/sync are sampled only when en=1
//   sync       in   frame start, marks din as bit 0 of slot 0
//   din        in   serial data, MSB of each slot first
//   ch0..ch3   out  per-slot data registers (WIDTH bits)
//   ch_valid   out  one-cycle strobe, bit n = chn updated this cycle
//   frame_done out  one-cycle strobe when slot 3 completes
//   frame_err  out  one-cycle strobe when sync arrives mid-frame
//   par_err    out  (TDM_DEMUX_PARITY_EN only) one-cycle per-slot parity error
// -----------------------------------------------------------------------------
module tdm_demux_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             din,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       ch_valid,
    output logic             frame_done,
    output logic             frame_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic [3:0]       par_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_LEN = WIDTH + 1;
`else
    localparam int SLOT_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_LEN - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q,      state_d;
    logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic [1:0]       slot_cnt_q,   slot_cnt_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [WIDTH-1:0] ch_q [4];
    logic [WIDTH-1:0] ch_d [4];
    logic [3:0]       ch_valid_q,   ch_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q,  frame_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic [3:0]       par_err_q,    par_err_d;
`endif

    // Shift register with the current bit appended; the MSB falls off.
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] slot_data;
    logic             slot_ok;

    assign shifted = WIDTH'({shift_q, din});

`ifdef TDM_DEMUX_PARITY_EN
    // On the parity-bit edge the shift register already holds all data bits.
    assign slot_data = shift_q;
    assign slot_ok   = ~^{shift_q, din};
`else
    assign slot_data = shifted;
    assign slot_ok   = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        shift_d      = shift_q;
        ch_d         = ch_q;
        ch_valid_d   = 4'b0000;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d    = 4'b0000;
`endif
        if (en) begin
            if (sync) begin
                // Sync in RUN (even on the very last bit of slot 3) aborts the
                // partial frame; already latched slots keep their values.
                if (state_q == ST_RUN) begin
                    frame_err_d = 1'b1;
                end
                state_d    = ST_RUN;
                shift_d    = {{(WIDTH-1){1'b0}}, din};
                bit_cnt_d  = CNT_W'(1);
                slot_cnt_d = 2'd0;
            end else if (state_q == ST_RUN) begin
                shift_d = shifted;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d  = '0;
                    slot_cnt_d = slot_cnt_q + 2'd1;
                    if (slot_ok) begin
                        ch_d[slot_cnt_q] = slot_data;
                        ch_valid_d       = 4'b0001 << slot_cnt_q;
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    else begin
                        par_err_d = 4'b0001 << slot_cnt_q;
                    end
`endif
                    if (slot_cnt_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        slot_cnt_d   = 2'd0;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= 2'd0;
            shift_q      <= '0;
            ch_q[0]      <= '0;
            ch_q[1]      <= '0;
            ch_q[2]      <= '0;
            ch_q[3]      <= '0;
            ch_valid_q   <= 4'b0000;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q    <= 4'b0000;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            ch_q         <= ch_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign ch0        = ch_q[0];
    assign ch1        = ch_q[1];
    assign ch2        = ch_q[2];
    assign ch3        = ch_q[3];
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err    = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1to4
// Table-driven bench for tdm_demux_1to4 (WIDTH=8). Frames are expanded into
// per-cycle records {en, sync, din, expected strobes, expected channel regs},
// applied one per clock and compared #1 after the rising edge. Reset and the
// asynchronous mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1to4;

    localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SL = W + 1;
`else
    localparam int SL = W;
`endif

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sync;
    logic         din;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic         frame_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic [3:0]   par_err;
`endif

    tdm_demux_1to4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync       (sync),
        .din        (din),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        sync;
        logic        din;
        logic [3:0]  vld;
        logic        done;
        logic        err;
        logic [3:0]  perr;
        logic [31:0] chs;     // {ch3,ch2,ch1,ch0}
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_ch;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expand one frame (bytes = {ch3,ch2,ch1,ch0}) into records. nbits < full
    // length truncates the frame; err_first marks a sync that lands mid-frame;
    // gap>0 inserts an en=0 cycle (with sync/din high, which must be ignored)
    // after every gap active bits; bad flips the parity bit of selected slots.
    task automatic push_frame(input logic [31:0] bytes, input int nbits,
                              input bit err_first, input int gap, input logic [3:0] bad);
        vec_t       r;
        int         slot;
        int         k;
        logic [7:0] byte_v;
        for (int b = 0; b < nbits; b++) begin
            if (gap > 0 && b > 0 && (b % gap) == 0) begin
                r.en = 1'b0; r.sync = 1'b1; r.din = 1'b1;
                r.vld = 4'b0; r.done = 1'b0; r.err = 1'b0; r.perr = 4'b0;
                r.chs = exp_ch;
                vq.push_back(r);
            end
            slot   = b / SL;
            k      = b % SL;
            byte_v = bytes[slot*8 +: 8];
            r.en   = 1'b1;
            r.sync = (b == 0);
            r.din  = (k < 8) ? byte_v[7-k] : ((^byte_v) ^ bad[slot]);
            r.vld  = 4'b0;
            r.perr = 4'b0;
            if (k == SL - 1) begin
                if (bad[slot]) begin
                    r.perr[slot] = 1'b1;
                end else begin
                    r.vld[slot] = 1'b1;
                    exp_ch[slot*8 +: 8] = byte_v;
                end
            end
            r.done = (b == 4*SL - 1);
            r.err  = (b == 0) && err_first;
            r.chs  = exp_ch;
            vq.push_back(r);
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            en   = vq[i].en;
            sync = vq[i].sync;
            din  = vq[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].ch_valid", tag, i),   {28'd0, ch_valid},   {28'd0, vq[i].vld});
            chk($sformatf("%s[%0d].frame_done", tag, i), {31'd0, frame_done}, {31'd0, vq[i].done});
            chk($sformatf("%s[%0d].frame_err", tag, i),  {31'd0, frame_err},  {31'd0, vq[i].err});
            chk($sformatf("%s[%0d].ch", tag, i),         {ch3, ch2, ch1, ch0}, vq[i].chs);
`ifdef TDM_DEMUX_PARITY_EN
            chk($sformatf("%s[%0d].par_err", tag, i),    {28'd0, par_err},    {28'd0, vq[i].perr});
`endif
        end
        vq.delete();
        en = 1'b0; sync = 1'b0; din = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ch_valid"},   {28'd0, ch_valid},   32'd0);
        chk({tag, ".frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, ".frame_err"},  {31'd0, frame_err},  32'd0);
        chk({tag, ".ch"},         {ch3, ch2, ch1, ch0}, 32'd0);
`ifdef TDM_DEMUX_PARITY_EN
        chk({tag, ".par_err"},    {28'd0, par_err},    32'd0);
`endif
    endtask

    initial begin
        vec_t r;
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;
        exp_ch = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Bits without sync in IDLE must be ignored
        for (int i = 0; i < 40; i++) begin
            r.en = 1'b1; r.sync = 1'b0; r.din = 1'b1;
            r.vld = 4'b0; r.done = 1'b0; r.err = 1'b0; r.perr = 4'b0;
            r.chs = 32'd0;
            vq.push_back(r);
        end
        run_vecs("idle");

        // Clean frame A5,3C,FF,01
        push_frame(32'h01FF3CA5, 4*SL, 1'b0, 0, 4'b0);
        run_vecs("clean");

        // Same frame with en=0 every third cycle
        push_frame(32'h01FF3CA5, 4*SL, 1'b0, 2, 4'b0);
        run_vecs("gaps");

        // Sync at bit 12, then a full frame 11,22,33,44
        push_frame(32'h66554477, 12, 1'b0, 0, 4'b0);
        push_frame(32'h44332211, 4*SL, 1'b1, 0, 4'b0);
        run_vecs("midsync");

        // Sync coincident with the last bit of slot 3: no frame_done, error instead
        push_frame(32'h0D0C0B0A, 4*SL - 1, 1'b0, 0, 4'b0);
        push_frame(32'h8899AABB, 4*SL, 1'b1, 0, 4'b0);
        run_vecs("lastsync");

        // Asynchronous reset mid-frame (after bit 20)
        push_frame(32'hDEADBEEF, 20, 1'b0, 0, 4'b0);
        run_vecs("prerst");
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("asyncrst");
        exp_ch = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(32'h0FF0C35A, 4*SL, 1'b0, 0, 4'b0);
        run_vecs("postrst");

`ifdef TDM_DEMUX_PARITY_EN
        // Slot 1 parity bad: ch1 unchanged, par_err pulse, frame_done still fires
        push_frame(32'h01FF3CA5, 4*SL, 1'b0, 0, 4'b0010);
        run_vecs("parity");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
